// File: rtl/uart_tx_arb_if.sv
// Bundle between the debug byte sources, the shared UART transmitter and the arbiter.
// Ports: req_dat/req_val/req_lst/req_rdy source side, txd/txv/tx_active UART side, gnt/busy/err_* status.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0] req_dat;
    logic [N_REQ-1:0]   req_val;
    logic [N_REQ-1:0]   req_lst;
    logic [N_REQ-1:0]   req_rdy;
    logic [7:0]         txd;
    logic               txv;
    logic               tx_active;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               err_start;
    logic               err_hold;

    // Arbiter side: consumes requests and UART status, drives everything else.
    modport slave (
        input  req_dat, req_val, req_lst, tx_active,
        output req_rdy, txd, txv, gnt, busy, err_start, err_hold
    );

    // Environment side: debug sources plus the UART transmitter.
    modport master (
        output req_dat, req_val, req_lst, tx_active,
        input  req_rdy, txd, txv, gnt, busy, err_start, err_hold
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, message-granular arbiter sharing one debug UART transmitter between N_REQ sources.
// Ports: clk, rst (async, active-high), bus (uart_tx_arb_if.slave: requests, UART strobe/status, gnt/busy/errors).
module uart_tx_arb #(
    parameter int N_REQ    = 4,
    parameter int START_TO = 16,
    parameter int HOLD_TO  = 65535
) (
    input logic          clk,
    input logic          rst,
    uart_tx_arb_if.slave bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = $clog2(START_TO + 1);
    localparam int HW = $clog2(HOLD_TO + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACT,
        WAIT_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       txd_q;
    logic             txv_q;
    logic [N_REQ-1:0] gnt_q;
    logic             busy_q;
    logic             err_start_q;
    logic             err_hold_q;
    logic             last_q;
    logic [PW-1:0]    rr_q;
    logic [SW-1:0]    start_q;
    logic [HW-1:0]    hold_q;

    logic [PW-1:0]    owner;
    logic [PW-1:0]    nxt_ptr;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;
    logic [N_REQ-1:0] pick_oh;
    logic             xfer;
    logic             start_exp;
    logic             hold_exp;
    logic             byte_done;

    // Index of the current owner; gnt_q is one-hot whenever it is used.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                owner = PW'(i);
            end
        end
    end

    // Released owner drops to lowest priority.
    assign nxt_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // First valid requester searching from rr_q upwards, modulo N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(rr_q) + k) % N_REQ);
            if (!pick_vld && bus.req_val[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_oh = N_REQ'(1) << pick_idx;

    // The only combinational output: ready is withheld while the UART is busy.
    assign bus.req_rdy = (state_q == ISSUE && !bus.tx_active) ? gnt_q : '0;

    assign xfer      = |(bus.req_val & bus.req_rdy);
    assign start_exp = (start_q == SW'(START_TO - 1));
    assign hold_exp  = (hold_q == HW'(HOLD_TO - 1));

    // A byte is finished when the UART goes idle again, or when it never
    // started and the start timeout gives up on it.
    assign byte_done = !bus.tx_active &&
                       ((state_q == WAIT_DONE) ||
                        (state_q == WAIT_ACT && start_exp));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            txd_q       <= '0;
            txv_q       <= 1'b0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            err_start_q <= 1'b0;
            err_hold_q  <= 1'b0;
            last_q      <= 1'b0;
            rr_q        <= '0;
            start_q     <= '0;
            hold_q      <= '0;
        end else begin
            txv_q       <= 1'b0;
            err_start_q <= 1'b0;
            err_hold_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_oh;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        txd_q   <= bus.req_dat[{owner, 3'b000} +: 8];
                        txv_q   <= 1'b1;
                        last_q  <= bus.req_lst[owner];
                        start_q <= '0;
                        state_q <= WAIT_ACT;
                    end else if (hold_exp) begin
                        // Owner stalled mid-message: revoke the grant.
                        err_hold_q <= 1'b1;
                        gnt_q      <= '0;
                        rr_q       <= nxt_ptr;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                WAIT_ACT, WAIT_DONE: begin
                    if (state_q == WAIT_ACT) begin
                        if (bus.tx_active) begin
                            state_q <= WAIT_DONE;
                        end else if (start_exp) begin
                            err_start_q <= 1'b1;
                        end else begin
                            start_q <= start_q + 1'b1;
                        end
                    end
                    if (byte_done) begin
                        if (last_q) begin
                            gnt_q   <= '0;
                            rr_q    <= nxt_ptr;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            hold_q  <= '0;
                            state_q <= ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.txd       = txd_q;
    assign bus.txv       = txv_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.err_start = err_start_q;
    assign bus.err_hold  = err_hold_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: sources, a UART model and a message-level arbitration model.
// Ports: none (top level); drives clk/rst and the master side of uart_tx_arb_if.
module tb_uart_tx_arb;

    localparam int N        = 4;
    localparam int UART_LEN = 10;

    typedef struct {
        logic [7:0]   d;
        logic [N-1:0] g;
        int           cyc;
    } rec_t;

    logic clk;
    logic rst;

    uart_tx_arb_if #(.N_REQ(N)) bus ();

    uart_tx_arb #(
        .N_REQ   (N),
        .START_TO(16),
        .HOLD_TO (20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] srcq [N][$];
    logic [8:0] mq   [N][$];
    rec_t       txlog[$];
    rec_t       expq [$];
    int         errh_cyc[$];
    int         errs_cyc[$];

    int n_chk, n_pass, cyc, act_fall_cyc;
    int uart_cnt, uart_dly, model_rr, xfer_idx;
    int viol_lat, viol_act, viol_b2b, viol_oh;
    bit dead, xfer_nxt, prev_txv;

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    // One clock: observe at the falling edge, update UART and sources,
    // then note whether a transfer will occur at the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (xfer_nxt) void'(srcq[xfer_idx].pop_front());
        if (bus.txv !== xfer_nxt) viol_lat++;
        if (bus.txv === 1'b1) begin
            if (prev_txv) viol_b2b++;
            if (bus.tx_active) viol_act++;
            if ($countones(bus.gnt) != 1) viol_oh++;
            txlog.push_back('{d: bus.txd, g: bus.gnt, cyc: cyc});
        end
        if ($countones(bus.gnt) > 1) viol_oh++;
        if ((bus.req_rdy & ~bus.gnt) != '0) viol_oh++;
        if (bus.err_hold === 1'b1) errh_cyc.push_back(cyc);
        if (bus.err_start === 1'b1) errs_cyc.push_back(cyc);
        prev_txv = bus.txv;
        if (bus.txv && !dead) uart_dly = $urandom_range(1, 3);
        if (uart_dly > 0) begin
            uart_dly--;
            if (uart_dly == 0) begin
                bus.tx_active = 1'b1;
                uart_cnt = UART_LEN;
            end
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                bus.tx_active = 1'b0;
                act_fall_cyc = cyc;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                bus.req_val[i]         = 1'b1;
                bus.req_dat[8*i +: 8]  = srcq[i][0][7:0];
                bus.req_lst[i]         = srcq[i][0][8];
            end else begin
                bus.req_val[i]         = 1'b0;
                bus.req_dat[8*i +: 8]  = 8'h00;
                bus.req_lst[i]         = 1'b0;
            end
        end
        #1;
        xfer_nxt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_val[i] && bus.req_rdy[i]) begin
                xfer_nxt = 1'b1;
                xfer_idx = i;
            end
        end
    endtask

    task automatic run_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            step();
            if (all_empty() && !bus.busy && !bus.tx_active &&
                uart_cnt == 0 && uart_dly == 0 && !xfer_nxt) ok = 1'b1;
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input bit lst, input bit mdl);
        srcq[r].push_back({lst, b});
        if (mdl) mq[r].push_back({lst, b});
    endtask

    // Whole-message round robin: pick the first requester with a pending
    // message from model_rr, emit that message, then rotate past it.
    task automatic build_expected();
        int           own;
        logic [8:0]   e;
        logic [N-1:0] oh;
        bit           done;
        expq.delete();
        forever begin
            own = -1;
            for (int k = 0; k < N; k++)
                if (own < 0 && mq[(model_rr + k) % N].size() > 0) own = (model_rr + k) % N;
            if (own < 0) break;
            oh = '0;
            oh[own] = 1'b1;
            done = 1'b0;
            while (!done) begin
                e = mq[own].pop_front();
                expq.push_back('{d: e[7:0], g: oh, cyc: 0});
                done = e[8] || (mq[own].size() == 0);
            end
            model_rr = (own + 1) % N;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        uart_cnt = 0;
        uart_dly = 0;
        bus.tx_active = 1'b0;
        xfer_nxt = 1'b0;
        prev_txv = 1'b0;
        model_rr = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        txlog.delete();
        errh_cyc.delete();
        errs_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.txv !== 1'b0) $display("FAIL rst_txv: got %b want 0", bus.txv); else n_pass++;
        n_chk++; if (bus.txd !== 8'h00) $display("FAIL rst_txd: got %h want 00", bus.txd); else n_pass++;
        n_chk++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", bus.gnt); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.req_rdy !== 4'b0000) $display("FAIL rst_rdy: got %b want 0000", bus.req_rdy); else n_pass++;
        n_chk++; if ({bus.err_start, bus.err_hold} !== 2'b00)
            $display("FAIL rst_err: got %b want 00", {bus.err_start, bus.err_hold}); else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        push(0, 8'h41, 1'b0, 1'b1);
        push(0, 8'h42, 1'b1, 1'b1);
        build_expected();
        run_idle(200, ok);
        n_chk++; if (!ok) $display("FAIL single_timeout: got busy, want idle within 200"); else n_pass++;
        n_chk++; if (txlog.size() !== 2) $display("FAIL single_count: got %0d want 2", txlog.size()); else n_pass++;
        for (int k = 0; k < 2 && k < txlog.size(); k++) begin
            n_chk++;
            if (txlog[k].d !== expq[k].d || txlog[k].g !== 4'b0001)
                $display("FAIL single_byte%0d: got %h/%b want %h/0001", k, txlog[k].d, txlog[k].g, expq[k].d);
            else n_pass++;
        end
        n_chk++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL single_end: got gnt %b busy %b want 0000 0", bus.gnt, bus.busy); else n_pass++;
        n_chk++; if (viol_lat !== 0) $display("FAIL single_latency: got %0d bad txv cycles want 0", viol_lat); else n_pass++;
        n_chk++; if (viol_act !== 0) $display("FAIL single_txv_active: got %0d want 0", viol_act); else n_pass++;
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        push(0, 8'h10, 1'b0, 1'b1); push(0, 8'h11, 1'b1, 1'b1);
        push(1, 8'h20, 1'b0, 1'b1); push(1, 8'h21, 1'b1, 1'b1);
        push(3, 8'h30, 1'b0, 1'b1); push(3, 8'h31, 1'b1, 1'b1);
        build_expected();
        run_idle(400, ok);
        n_chk++; if (!ok) $display("FAIL cont_timeout: got busy, want idle within 400"); else n_pass++;
        n_chk++; if (txlog.size() !== expq.size())
            $display("FAIL cont_count: got %0d want %0d", txlog.size(), expq.size()); else n_pass++;
        for (int k = 0; k < expq.size() && k < txlog.size(); k++) begin
            n_chk++;
            if (txlog[k].d !== expq[k].d || txlog[k].g !== expq[k].g)
                $display("FAIL cont_byte%0d: got %h/%b want %h/%b", k, txlog[k].d, txlog[k].g, expq[k].d, expq[k].g);
            else n_pass++;
        end
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        push(0, 8'hA0, 1'b0, 1'b1); push(0, 8'hA1, 1'b1, 1'b1);
        push(0, 8'hA2, 1'b1, 1'b1);
        push(2, 8'hC0, 1'b0, 1'b1); push(2, 8'hC1, 1'b1, 1'b1);
        build_expected();
        run_idle(400, ok);
        n_chk++; if (!ok) $display("FAIL fair_timeout: got busy, want idle within 400"); else n_pass++;
        n_chk++; if (txlog.size() !== expq.size())
            $display("FAIL fair_count: got %0d want %0d", txlog.size(), expq.size()); else n_pass++;
        for (int k = 0; k < expq.size() && k < txlog.size(); k++) begin
            n_chk++;
            if (txlog[k].d !== expq[k].d || txlog[k].g !== expq[k].g)
                $display("FAIL fair_byte%0d: got %h/%b want %h/%b", k, txlog[k].d, txlog[k].g, expq[k].d, expq[k].g);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit           ok;
        logic [N-1:0] gnt_at_err;
        do_reset();
        push(1, 8'h55, 1'b0, 1'b0);
        push(2, 8'h66, 1'b1, 1'b0);
        gnt_at_err = 'x;
        for (int k = 0; k < 200 && errh_cyc.size() == 0; k++) begin
            step();
            if (errh_cyc.size() > 0) gnt_at_err = bus.gnt;
        end
        n_chk++; if (errh_cyc.size() !== 1) $display("FAIL stall_err_seen: got %0d pulses want 1", errh_cyc.size()); else n_pass++;
        if (errh_cyc.size() > 0) begin
            n_chk++;
            if (errh_cyc[0] - act_fall_cyc !== 21)
                $display("FAIL stall_err_time: got %0d want 21", errh_cyc[0] - act_fall_cyc);
            else n_pass++;
        end
        n_chk++; if (gnt_at_err !== 4'b0000) $display("FAIL stall_gnt_clr: got %b want 0000", gnt_at_err); else n_pass++;
        run_idle(200, ok);
        n_chk++; if (!ok) $display("FAIL stall_timeout: got busy, want idle within 200"); else n_pass++;
        n_chk++; if (txlog.size() !== 2) $display("FAIL stall_count: got %0d want 2", txlog.size()); else n_pass++;
        if (txlog.size() == 2) begin
            n_chk++;
            if (txlog[0].d !== 8'h55 || txlog[0].g !== 4'b0010 ||
                txlog[1].d !== 8'h66 || txlog[1].g !== 4'b0100)
                $display("FAIL stall_seq: got %h/%b %h/%b want 55/0010 66/0100",
                         txlog[0].d, txlog[0].g, txlog[1].d, txlog[1].g);
            else n_pass++;
        end
        n_chk++; if (errh_cyc.size() !== 1) $display("FAIL stall_err_once: got %0d want 1", errh_cyc.size()); else n_pass++;
    endtask

    task automatic test_dead_uart();
        bit ok;
        do_reset();
        dead = 1'b1;
        push(3, 8'hA5, 1'b0, 1'b0);
        push(3, 8'h5A, 1'b1, 1'b0);
        run_idle(300, ok);
        dead = 1'b0;
        n_chk++; if (!ok) $display("FAIL dead_timeout: got busy, want idle within 300"); else n_pass++;
        n_chk++; if (txlog.size() !== 2 || errs_cyc.size() !== 2)
            $display("FAIL dead_count: got %0d txv %0d err want 2 2", txlog.size(), errs_cyc.size()); else n_pass++;
        if (txlog.size() == 2 && errs_cyc.size() == 2) begin
            n_chk++;
            if (txlog[0].d !== 8'hA5 || txlog[1].d !== 8'h5A || txlog[1].g !== 4'b1000)
                $display("FAIL dead_bytes: got %h %h/%b want a5 5a/1000", txlog[0].d, txlog[1].d, txlog[1].g);
            else n_pass++;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (errs_cyc[k] - txlog[k].cyc !== 16)
                    $display("FAIL dead_err_time%0d: got %0d want 16", k, errs_cyc[k] - txlog[k].cyc);
                else n_pass++;
            end
        end
        n_chk++; if (bus.gnt !== 4'b0000) $display("FAIL dead_gnt_end: got %b want 0000", bus.gnt); else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int nmsg, len;
        for (int r = 0; r < 5; r++) begin
            txlog.delete();
            for (int i = 0; i < N; i++) begin
                nmsg = $urandom_range(0, 2);
                if (r == 0 && i == 0) nmsg = 1;
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        push(i, 8'($urandom_range(0, 255)), (b == len - 1), 1'b1);
                end
            end
            build_expected();
            run_idle(1500, ok);
            n_chk++; if (!ok) $display("FAIL rand%0d_timeout: got busy, want idle", r); else n_pass++;
            n_chk++; if (txlog.size() !== expq.size())
                $display("FAIL rand%0d_count: got %0d want %0d", r, txlog.size(), expq.size()); else n_pass++;
            for (int k = 0; k < expq.size() && k < txlog.size(); k++) begin
                n_chk++;
                if (txlog[k].d !== expq[k].d || txlog[k].g !== expq[k].g)
                    $display("FAIL rand%0d_byte%0d: got %h/%b want %h/%b",
                             r, k, txlog[k].d, txlog[k].g, expq[k].d, expq[k].g);
                else n_pass++;
            end
        end
        n_chk++; if (viol_lat !== 0) $display("FAIL proto_latency: got %0d want 0", viol_lat); else n_pass++;
        n_chk++; if (viol_act !== 0) $display("FAIL proto_txv_active: got %0d want 0", viol_act); else n_pass++;
        n_chk++; if (viol_b2b !== 0) $display("FAIL proto_txv_b2b: got %0d want 0", viol_b2b); else n_pass++;
        n_chk++; if (viol_oh !== 0) $display("FAIL proto_onehot: got %0d want 0", viol_oh); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        do_reset();
        push(0, 8'h01, 1'b1, 1'b0);
        run_idle(200, ok);
        push(2, 8'h10, 1'b0, 1'b0);
        push(2, 8'h11, 1'b0, 1'b0);
        push(2, 8'h12, 1'b1, 1'b0);
        k = 0;
        while (k < 200 && !(txlog.size() == 2 && bus.tx_active === 1'b1)) begin
            step();
            k++;
        end
        repeat (2) step();
        n_chk++; if (k >= 200 || bus.busy !== 1'b1 || bus.gnt !== 4'b0100)
            $display("FAIL rmid_setup: got busy %b gnt %b want 1 0100", bus.busy, bus.gnt); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.txv !== 1'b0 ||
            bus.txd !== 8'h00 || bus.req_rdy !== 4'b0000)
            $display("FAIL rmid_async: got gnt %b busy %b txv %b txd %h rdy %b want all zero",
                     bus.gnt, bus.busy, bus.txv, bus.txd, bus.req_rdy);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        xfer_nxt = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        txlog.delete();
        model_rr = 0;
        push(0, 8'h20, 1'b1, 1'b1);
        push(1, 8'h21, 1'b1, 1'b1);
        build_expected();
        run_idle(300, ok);
        n_chk++; if (!ok) $display("FAIL rmid_timeout: got busy, want idle within 300"); else n_pass++;
        n_chk++; if (txlog.size() !== expq.size())
            $display("FAIL rmid_count: got %0d want %0d", txlog.size(), expq.size()); else n_pass++;
        for (int j = 0; j < expq.size() && j < txlog.size(); j++) begin
            n_chk++;
            if (txlog[j].d !== expq[j].d || txlog[j].g !== expq[j].g)
                $display("FAIL rmid_byte%0d: got %h/%b want %h/%b", j, txlog[j].d, txlog[j].g, expq[j].d, expq[j].g);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_val = '0;
        bus.req_lst = '0;
        bus.req_dat = '0;
        bus.tx_active = 1'b0;
        n_chk = 0; n_pass = 0; cyc = 0; act_fall_cyc = 0;
        uart_cnt = 0; uart_dly = 0; model_rr = 0; xfer_idx = 0;
        viol_lat = 0; viol_act = 0; viol_b2b = 0; viol_oh = 0;
        dead = 1'b0; xfer_nxt = 1'b0; prev_txv = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stall();
        test_dead_uart();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares the single debug UART transmitter between N_REQ byte-stream requesters, so several debug sources can print over one serial line.
- Arbitrates round-robin at message granularity: once a requester is granted, it owns the line until it sends a byte flagged last, or until it stalls.
- Sequences the UART one byte at a time: a one-cycle txv pulse, then waits for tx_active to rise and fall before the next byte.
- Sits between the debug sources and the uart txd/txv/tx_active ports, in the transmitter's clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TO, 16, cycles to wait for tx_active to rise after a txv pulse before flagging err_start.
- HOLD_TO, 65535, idle cycles a granted requester may stall mid-message before its grant is revoked.

Ports:
- clk  in  1  single clock, same as the UART transmit clock.
- rst  in  1  asynchronous, active-high reset.
- req_dat  in  8*N_REQ  byte from requester i, at bits [8i+7:8i].
- req_val  in  N_REQ  requester i has a byte on req_dat.
- req_lst  in  N_REQ  the byte is the last of requester i's message.
- req_rdy  out  N_REQ  byte accepted; a transfer occurs when req_val[i] & req_rdy[i] are both high at a clock edge.
- txd  out  8  byte to the UART.
- txv  out  1  one-cycle transmit strobe to the UART.
- tx_active  in  1  UART transmitter busy.
- gnt  out  N_REQ  one-hot current owner; all zero when no owner.
- busy  out  1  high in any state except IDLE.
- err_start  out  1  one-cycle pulse: START_TO expired in WAIT_ACT.
- err_hold  out  1  one-cycle pulse: HOLD_TO expired in ISSUE.

Behaviour:
- Reset values:
  - state=IDLE; txd=0; txv=0; gnt=0; req_rdy=0; busy=0; err_start=0; err_hold=0.
  - rr_ptr=0; both timers=0; last_flag=0.
- Reset asserted mid-operation aborts immediately. No byte is replayed; a UART frame already in flight completes on its own.
- All outputs are registered except req_rdy. req_rdy[i] = (state==ISSUE) & gnt[i] & ~tx_active.
- IDLE:
  - If any req_val is high, grant the first requester with req_val set, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Load gnt as one-hot, clear the hold timer, go to ISSUE.
  - If no req_val is high, stay in IDLE.
- ISSUE:
  - On a transfer from the granted requester: txd<=req_dat[gnt], txv<=1 for exactly the next cycle, last_flag<=req_lst[gnt], clear the start timer, go to WAIT_ACT.
  - Accept-to-txv latency is 1 cycle.
  - Otherwise the hold timer increments each cycle. When it reaches HOLD_TO-1: pulse err_hold, gnt<=0, rr_ptr<=owner+1, go to IDLE.
  - req_val from non-granted requesters is ignored; their req_rdy stays low.
- WAIT_ACT:
  - If tx_active=1, go to WAIT_DONE.
  - Otherwise the start timer increments. At START_TO-1: pulse err_start and treat the byte as sent, i.e. take the same exit as WAIT_DONE.
- WAIT_DONE:
  - Stay while tx_active=1.
  - On tx_active=0, if last_flag=1: gnt<=0, rr_ptr<=owner+1 (wraps at N_REQ), go to IDLE.
  - On tx_active=0, if last_flag=0: clear the hold timer, go back to ISSUE.
- Minimum gap between transfers: txv is never asserted while tx_active=1 or in consecutive cycles.
- A single-byte message is one transfer with req_lst=1.
- Simultaneous requests are resolved purely by rr_ptr order.
- A requester that deasserts req_val mid-message keeps its grant until HOLD_TO expires.
- After any release, the owner becomes lowest priority: rr_ptr = owner+1.

Test Plan:
- Single requester: req0 sends 0x41, 0x42 (lst on 0x42) against a UART model with 10-cycle tx_active.
  → Two txv pulses with txd 0x41 then 0x42; each txv is one cycle after its req_rdy transfer; second txv only after tx_active falls; gnt=0001 throughout, then 0; busy returns low.
- Contention: req0, req1 and req3 each hold a 2-byte message, all valid in the same cycle after reset.
  → Service order is req0, req1, req3; messages are never interleaved; gnt one-hot each time.
- Fairness: req0 continuously re-requests while req2 waits.
  → After req0's message ends, req2 is granted before req0's next message.
- Stall: owner sends 1 byte without lst, then drops req_val; HOLD_TO=20.
  → err_hold pulses once 20 cycles into ISSUE; gnt clears; the next pending requester is granted.
- UART dead: tx_active tied 0, START_TO=16.
  → err_start pulses 16 cycles after txv; the byte is treated as sent and the FSM proceeds per last_flag.
- Reset mid-message, asserted in WAIT_DONE.
  → All outputs return to their reset values asynchronously; after release, arbitration restarts at rr_ptr=0.
